multicycle_control: RTL and testbench
=====================================

# multicycle_control

Sequencing control unit for the multi-cycle build of the 8-bit datapath. It replaces the single-cycle opcode decoder with a state machine that steps each instruction through fetch, decode, execute, memory and writeback. It also stalls on a memory ready handshake and traps on opcodes outside the defined set. It sits between the instruction register and the datapath enables: PC, IR, register file, ALU and data memory.

## Interface
- OP_W, 2, opcode width in bits; must be ≥ 2. Codes 0..3 are defined; codes ≥ 4 are illegal.
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- opcode  in  OP_W  opcode field from the IR output; sampled in DECODE.
- mem_ready  in  1  memory handshake; an access completes in any cycle where the request is high and mem_ready=1.
- PCWrite, IRWrite, RegDst, RegWrite, ALUsrc, Branch, MemRead, MemWrite, MemtoReg, ALUOp  out  1 each  datapath enables.
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction.
- halt  out  1  high while in TRAP.

## Operation
- Opcodes: 0 = R, 1 = LW, 2 = SW, 3 = J. The opcode is latched into op_q on the DECODE cycle. All later states use op_q, never the live opcode.
- States:
  - FETCH: MemRead=1. IRWrite=mem_ready, PCWrite=mem_ready (PC+1). Go to DECODE on mem_ready, otherwise stay.
  - DECODE: capture op_q.
    - R, LW or SW: go to EXEC.
    - J: Branch=1, PCWrite=1, instr_done=1, go to FETCH.
    - Illegal: go to TRAP.
  - EXEC: ALUOp=1. ALUsrc=1 for LW/SW, 0 for R. R goes to WB; LW and SW go to MEM.
  - MEM: ALUsrc=1. LW drives MemRead=1; SW drives MemWrite=1. Stay until mem_ready.
    - LW: go to WB on mem_ready.
    - SW: on mem_ready, instr_done=1 and go to FETCH.
  - WB: RegWrite=1, instr_done=1, go to FETCH.
    - R: RegDst=1, MemtoReg=0.
    - LW: RegDst=0, MemtoReg=1.
  - TRAP: halt=1 and every other output is 0. Only reset leaves this state.
- Any output not listed for a state is 0.
- Outputs are combinational from the state, op_q, opcode (in DECODE) and mem_ready (in FETCH/MEM). No output may depend on mem_ready outside those two states.
- mem_ready is ignored in DECODE, EXEC, WB and TRAP.

## Timing
- reset held: the next state is FETCH, op_q=0, and every output, including halt and instr_done, is forced to 0 during the reset cycle.
- First FETCH request: MemRead rises in the cycle after reset deasserts.
- Reset mid-instruction, including while stalled in MEM or while in TRAP: the FSM aborts and returns to FETCH on the next edge. No write enable may be asserted during the reset cycle.
- Minimum latency with zero-wait memory (mem_ready tied 1): J = 2 cycles, R = 4, SW = 4, LW = 5.
- Each cycle with mem_ready=0 in FETCH or MEM adds exactly one cycle.
- instr_done occurs exactly once per completed instruction and never in TRAP.
- Back-to-back instructions: FETCH of the next instruction immediately follows the instr_done cycle, with no bubble.

## Structure
- Shared package ctrl_pkg contains:
  - the state enum: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5, on 3 bits;
  - opcode constants OP_R, OP_LW, OP_SW, OP_J;
  - the instruction-class enum {CLS_R, CLS_LW, CLS_SW, CLS_J, CLS_ILL}.
- Sub-module op_class: a combinational map from opcode[OP_W-1:0] to the class. Any value ≥ 4 maps to CLS_ILL.
- The top level holds the state register, op_q, and the output decode.

## Test plan
- Zero-wait R: opcode=0, mem_ready=1 → states FETCH, DECODE, EXEC, WB. IRWrite and PCWrite in cycle 1, ALUOp=1 with ALUsrc=0 in cycle 3, RegWrite=1 with RegDst=1 and instr_done=1 in cycle 4.
- LW with 2 wait states in MEM: mem_ready low for 2 cycles → MemRead held 3 cycles in MEM, then WB with MemtoReg=1. Total 7 cycles.
- SW then J, back to back, zero-wait → MemWrite pulses once and no RegWrite occurs. The J DECODE cycle shows Branch=1, PCWrite=1, instr_done=1. Total 6 cycles with 2 instr_done pulses.
- FETCH stall: mem_ready=0 for 3 cycles → MemRead=1, IRWrite=0, PCWrite=0 throughout, state stays FETCH. On the 4th cycle IRWrite=PCWrite=1.
- OP_W=3, opcode=5 → TRAP after DECODE. halt=1 and every other output is 0 for 10 or more cycles. Reset returns the FSM to FETCH.
- Reset asserted while stalled in MEM for SW → no MemWrite in the reset cycle. FETCH follows, and op_q is recaptured on the next DECODE.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared types for the multi-cycle sequencing control unit: FSM states,
// opcode encodings, instruction classes and the datapath-enable bundle.
package ctrl_pkg;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      TRAP   = 3'd5
   } state_e;

   localparam logic [1:0] OP_R  = 2'd0;
   localparam logic [1:0] OP_LW = 2'd1;
   localparam logic [1:0] OP_SW = 2'd2;
   localparam logic [1:0] OP_J  = 2'd3;

   typedef enum logic [2:0] {
      CLS_R,
      CLS_LW,
      CLS_SW,
      CLS_J,
      CLS_ILL
   } op_class_e;

   typedef struct packed {
      logic pc_write;
      logic ir_write;
      logic reg_dst;
      logic reg_write;
      logic alu_src;
      logic branch;
      logic mem_read;
      logic mem_write;
      logic mem_to_reg;
      logic alu_op;
      logic instr_done;
      logic halt;
   } ctrl_t;

endpackage

// File: rtl/op_class.sv
// Combinational opcode classifier; any opcode with bits above [1:0] set is
// outside the defined set and maps to CLS_ILL.
module op_class
   import ctrl_pkg::*;
#(
   parameter int OP_W = 2
) (
   input  logic [OP_W-1:0] i_opcode,
   output op_class_e       o_cls
);

   logic w_high;

   generate
      if (OP_W > 2) begin : g_wide
         assign w_high = |i_opcode[OP_W-1:2];
      end else begin : g_narrow
         assign w_high = 1'b0;
      end
   endgenerate

   always_comb begin
      // NOTE: assign a default before any branch so no path leaves o_cls unassigned (no latch).
      o_cls = CLS_ILL;
      if (!w_high) begin
         case (i_opcode[1:0])
            OP_R:    o_cls = CLS_R;
            OP_LW:   o_cls = CLS_LW;
            OP_SW:   o_cls = CLS_SW;
            OP_J:    o_cls = CLS_J;
            default: o_cls = CLS_ILL;
         endcase
      end
   end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencing FSM: steps each instruction through FETCH, DECODE,
// EXEC, MEM and WB, stalls on mem_ready and traps on illegal opcodes.
module multicycle_control
   import ctrl_pkg::*;
#(
   parameter int OP_W = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [OP_W-1:0] opcode,
   input  logic            mem_ready,
   output logic            PCWrite,
   output logic            IRWrite,
   output logic            RegDst,
   output logic            RegWrite,
   output logic            ALUsrc,
   output logic            Branch,
   output logic            MemRead,
   output logic            MemWrite,
   output logic            MemtoReg,
   output logic            ALUOp,
   output logic            instr_done,
   output logic            halt
);

   state_e          r_state;
   state_e          w_next;
   logic [OP_W-1:0] r_op_q;
   op_class_e       w_cls_live;
   op_class_e       w_cls_q;
   ctrl_t           w_ctrl;

   op_class #(.OP_W(OP_W)) u_cls_live (.i_opcode(opcode), .o_cls(w_cls_live));
   op_class #(.OP_W(OP_W)) u_cls_q    (.i_opcode(r_op_q), .o_cls(w_cls_q));

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= FETCH;
         r_op_q  <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == DECODE) begin
            r_op_q <= opcode;
         end
      end
   end

   always_comb begin
      w_next = r_state;
      w_ctrl = '0;
      case (r_state)
         FETCH: begin
            w_ctrl.mem_read = 1'b1;
            w_ctrl.ir_write = mem_ready;
            w_ctrl.pc_write = mem_ready;
            if (mem_ready) w_next = DECODE;
         end
         DECODE: begin
            // Only this state looks at the live opcode; later states use r_op_q.
            case (w_cls_live)
               CLS_R, CLS_LW, CLS_SW: w_next = EXEC;
               CLS_J: begin
                  w_ctrl.branch     = 1'b1;
                  w_ctrl.pc_write   = 1'b1;
                  w_ctrl.instr_done = 1'b1;
                  w_next            = FETCH;
               end
               default: w_next = TRAP;
            endcase
         end
         EXEC: begin
            w_ctrl.alu_op = 1'b1;
            case (w_cls_q)
               CLS_R:         w_next = WB;
               CLS_LW, CLS_SW: begin
                  w_ctrl.alu_src = 1'b1;
                  w_next         = MEM;
               end
               default:       w_next = TRAP;
            endcase
         end
         MEM: begin
            w_ctrl.alu_src = 1'b1;
            if (w_cls_q == CLS_LW) begin
               w_ctrl.mem_read = 1'b1;
               if (mem_ready) w_next = WB;
            end else if (w_cls_q == CLS_SW) begin
               w_ctrl.mem_write = 1'b1;
               if (mem_ready) begin
                  w_ctrl.instr_done = 1'b1;
                  w_next            = FETCH;
               end
            end else begin
               w_next = TRAP;
            end
         end
         WB: begin
            w_ctrl.reg_write  = 1'b1;
            w_ctrl.instr_done = 1'b1;
            w_ctrl.reg_dst    = (w_cls_q == CLS_R);
            w_ctrl.mem_to_reg = (w_cls_q == CLS_LW);
            w_next            = FETCH;
         end
         TRAP: begin
            w_ctrl.halt = 1'b1;
         end
         default: w_next = FETCH;
      endcase
      // Reset cycle must never expose a write enable, even from a stalled MEM.
      if (reset) w_ctrl = '0;
   end

   assign PCWrite    = w_ctrl.pc_write;
   assign IRWrite    = w_ctrl.ir_write;
   assign RegDst     = w_ctrl.reg_dst;
   assign RegWrite   = w_ctrl.reg_write;
   assign ALUsrc     = w_ctrl.alu_src;
   assign Branch     = w_ctrl.branch;
   assign MemRead    = w_ctrl.mem_read;
   assign MemWrite   = w_ctrl.mem_write;
   assign MemtoReg   = w_ctrl.mem_to_reg;
   assign ALUOp      = w_ctrl.alu_op;
   assign instr_done = w_ctrl.instr_done;
   assign halt       = w_ctrl.halt;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected enable vectors are
// queued as stimulus is driven and compared on the falling edge.
module tb_multicycle_control;

   localparam logic [11:0] M_PC   = 12'h800;
   localparam logic [11:0] M_IR   = 12'h400;
   localparam logic [11:0] M_RD   = 12'h200;
   localparam logic [11:0] M_RW   = 12'h100;
   localparam logic [11:0] M_AS   = 12'h080;
   localparam logic [11:0] M_BR   = 12'h040;
   localparam logic [11:0] M_MR   = 12'h020;
   localparam logic [11:0] M_MW   = 12'h010;
   localparam logic [11:0] M_MTR  = 12'h008;
   localparam logic [11:0] M_ALU  = 12'h004;
   localparam logic [11:0] M_DONE = 12'h002;
   localparam logic [11:0] M_HALT = 12'h001;
   localparam logic [11:0] E_FETCH = M_MR | M_IR | M_PC;

   typedef struct {
      string       tag;
      logic [11:0] e2;
      logic [11:0] e3;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst2, rst3;
   logic [1:0]  opcode2;
   logic [2:0]  opcode3;
   logic        mem_ready;
   logic [11:0] obs2, obs3;
   exp_t        sb[$];
   int          n_checks = 0;
   int          n_errors = 0;

   always #5 clk = ~clk;

   multicycle_control #(.OP_W(2)) dut (
      .clk(clk), .reset(rst2), .opcode(opcode2), .mem_ready(mem_ready),
      .PCWrite(obs2[11]), .IRWrite(obs2[10]), .RegDst(obs2[9]), .RegWrite(obs2[8]),
      .ALUsrc(obs2[7]), .Branch(obs2[6]), .MemRead(obs2[5]), .MemWrite(obs2[4]),
      .MemtoReg(obs2[3]), .ALUOp(obs2[2]), .instr_done(obs2[1]), .halt(obs2[0])
   );

   multicycle_control #(.OP_W(3)) dut3 (
      .clk(clk), .reset(rst3), .opcode(opcode3), .mem_ready(mem_ready),
      .PCWrite(obs3[11]), .IRWrite(obs3[10]), .RegDst(obs3[9]), .RegWrite(obs3[8]),
      .ALUsrc(obs3[7]), .Branch(obs3[6]), .MemRead(obs3[5]), .MemWrite(obs3[4]),
      .MemtoReg(obs3[3]), .ALUOp(obs3[2]), .instr_done(obs3[1]), .halt(obs3[0])
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Monitor: one expected entry per cycle, compared mid-cycle.
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         check({e.tag, "/w2"}, {20'd0, obs2}, {20'd0, e.e2});
         check({e.tag, "/w3"}, {20'd0, obs3}, {20'd0, e.e3});
      end
   end

   // Drive one cycle of stimulus for both DUTs and queue the expected outputs.
   task automatic step2(input string tag, input logic r2, input logic r3, input logic [2:0] op,
                        input logic mr, input logic [11:0] e2, input logic [11:0] e3);
      exp_t e;
      rst2      = r2;
      rst3      = r3;
      opcode2   = op[1:0];
      opcode3   = op;
      mem_ready = mr;
      e.tag = tag;
      e.e2  = e2;
      e.e3  = e3;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic step(input string tag, input logic [2:0] op, input logic mr, input logic [11:0] e);
      step2(tag, 1'b0, 1'b0, op, mr, e, e);
   endtask

   task automatic rst_step(input string tag);
      step2(tag, 1'b1, 1'b1, 3'd0, 1'b1, 12'h000, 12'h000);
   endtask

   initial begin
      rst2 = 1'b1; rst3 = 1'b1; opcode2 = '0; opcode3 = '0; mem_ready = 1'b1;
      @(posedge clk);
      #1;
      rst_step("reset0");
      rst_step("reset1");

      // Zero-wait R; opcode changed after DECODE to confirm op_q is used.
      step("r_fetch",  3'd0, 1'b1, E_FETCH);
      step("r_decode", 3'd0, 1'b1, 12'h000);
      step("r_exec",   3'd3, 1'b1, M_ALU);
      step("r_wb",     3'd2, 1'b1, M_RW | M_RD | M_DONE);

      // LW with two MEM wait states.
      step("lw_fetch",  3'd1, 1'b1, E_FETCH);
      step("lw_decode", 3'd1, 1'b1, 12'h000);
      step("lw_exec",   3'd0, 1'b1, M_ALU | M_AS);
      step("lw_mem0",   3'd0, 1'b0, M_AS | M_MR);
      step("lw_mem1",   3'd0, 1'b0, M_AS | M_MR);
      step("lw_mem2",   3'd0, 1'b1, M_AS | M_MR);
      step("lw_wb",     3'd0, 1'b1, M_RW | M_MTR | M_DONE);

      // SW then J back to back, zero-wait.
      step("sw_fetch",  3'd2, 1'b1, E_FETCH);
      step("sw_decode", 3'd2, 1'b1, 12'h000);
      step("sw_exec",   3'd3, 1'b1, M_ALU | M_AS);
      step("sw_mem",    3'd3, 1'b1, M_AS | M_MW | M_DONE);
      step("j_fetch",   3'd3, 1'b1, E_FETCH);
      step("j_decode",  3'd3, 1'b1, M_BR | M_PC | M_DONE);

      // FETCH stall, then R with mem_ready low where it must be ignored.
      for (int i = 0; i < 3; i++) step("fetch_stall", 3'd0, 1'b0, M_MR);
      step("stall_fetch_go", 3'd0, 1'b1, E_FETCH);
      step("stall_decode",   3'd0, 1'b0, 12'h000);
      step("stall_exec",     3'd0, 1'b0, M_ALU);
      step("stall_wb",       3'd0, 1'b0, M_RW | M_RD | M_DONE);

      // Zero-wait LW: five cycles.
      step("lw0_fetch",  3'd1, 1'b1, E_FETCH);
      step("lw0_decode", 3'd1, 1'b1, 12'h000);
      step("lw0_exec",   3'd1, 1'b1, M_ALU | M_AS);
      step("lw0_mem",    3'd1, 1'b1, M_AS | M_MR);
      step("lw0_wb",     3'd1, 1'b1, M_RW | M_MTR | M_DONE);

      // Illegal opcode 5 on the 3-bit instance; the 2-bit instance is held in reset.
      step2("trap_fetch",  1'b1, 1'b0, 3'd5, 1'b1, 12'h000, E_FETCH);
      step2("trap_decode", 1'b1, 1'b0, 3'd5, 1'b1, 12'h000, 12'h000);
      for (int i = 0; i < 12; i++)
         step2("trap_hold", 1'b1, 1'b0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               12'h000, M_HALT);
      rst_step("trap_reset");
      step("post_trap_fetch",  3'd3, 1'b1, E_FETCH);
      step("post_trap_decode", 3'd3, 1'b1, M_BR | M_PC | M_DONE);

      // Opcode 4 is illegal for the 3-bit instance, but its low bits decode as R on the 2-bit one.
      step("op4_fetch",  3'd4, 1'b1, E_FETCH);
      step2("op4_decode", 1'b0, 1'b0, 3'd4, 1'b1, 12'h000, 12'h000);
      step2("op4_next",   1'b0, 1'b0, 3'd4, 1'b1, M_ALU, M_HALT);
      step2("op4_wb",     1'b0, 1'b0, 3'd4, 1'b1, M_RW | M_RD | M_DONE, M_HALT);
      rst_step("op4_reset");

      // Reset while SW is stalled in MEM, then an R whose op_q must be recaptured.
      step("swr_fetch",  3'd2, 1'b1, E_FETCH);
      step("swr_decode", 3'd2, 1'b1, 12'h000);
      step("swr_exec",   3'd2, 1'b1, M_ALU | M_AS);
      step("swr_mem",    3'd2, 1'b0, M_AS | M_MW);
      rst_step("swr_reset");
      step("rr_fetch",  3'd0, 1'b1, E_FETCH);
      step("rr_decode", 3'd0, 1'b1, 12'h000);
      step("rr_exec",   3'd2, 1'b1, M_ALU);
      step("rr_wb",     3'd2, 1'b1, M_RW | M_RD | M_DONE);

      @(negedge clk);
      #1;
      check("scoreboard_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
